// File: rtl/ir_drv_pkg.sv
// Shared definitions for the IR LED driver controller.
//   state_t    : controller FSM states
//   PWM_W_DEF  : default PWM counter/duty width
//   TIME_W_DEF : default delay/strobe-width counter width
package ir_drv_pkg;

    localparam int PWM_W_DEF  = 8;
    localparam int TIME_W_DEF = 16;

    typedef enum logic [2:0] {
        OFF,
        WARMUP,
        ARMED,
        DELAY,
        STROBE
    } state_t;

endpackage

// File: rtl/ir_pwm_gen.sv
// PWM generator shared by both LED channels.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   run  : 1 while the strobe is (about to be) active; 0 holds the counter at 0
//   duty : high cycles per 2**PWM_W period
//   pwm  : run & (cnt < duty), combinational so the caller can register it
//          alongside its enable outputs
module ir_pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);

    logic [PWM_W-1:0] r_cnt;

    // Counter sits at 0 outside the strobe, so the first strobe cycle sees
    // cnt = 0; it wraps naturally at 2**PWM_W-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_cnt <= '0;
        else if (run)  r_cnt <= r_cnt + PWM_W'(1);
        else           r_cnt <= '0;
    end

    assign pwm = run && (r_cnt < duty);

endmodule

// File: rtl/ir_strobe_ctrl.sv
// Frame-synchronous IR illumination controller feeding the IR500 LED driver.
// Enables the current reference, waits for bias settle, then fires one
// delayed, PWM-dimmed strobe per frame trigger on the selected channel(s).
//   clk, rst           : clock, asynchronous active-high reset
//   en                 : level enable; 0 forces everything off
//   trig               : single-cycle frame-sync pulse
//   cfg_delay/width    : trigger-to-strobe delay and strobe length (cycles)
//   cfg_duty           : PWM high cycles per period
//   cfg_ch             : [0] LED1 enable, [1] LED2 enable
//   curren             : driver CURREN
//   irleden/irpwm      : driver channel 1 enable / PWM
//   irleden2/irpwm2    : driver channel 2 enable / PWM
//   ready              : next trig will be accepted
//   overrun            : 1-cycle pulse, trig dropped
module ir_strobe_ctrl
    import ir_drv_pkg::*;
#(
    parameter int PWM_W         = PWM_W_DEF,
    parameter int TIME_W        = TIME_W_DEF,
    parameter int WARMUP_CYCLES = 1200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              trig,
    input  logic [TIME_W-1:0] cfg_delay,
    input  logic [TIME_W-1:0] cfg_width,
    input  logic [PWM_W-1:0]  cfg_duty,
    input  logic [1:0]        cfg_ch,
    output logic              curren,
    output logic              irleden,
    output logic              irpwm,
    output logic              irleden2,
    output logic              irpwm2,
    output logic              ready,
    output logic              overrun
);

    localparam int WU_W = $clog2(WARMUP_CYCLES + 1);

    state_t            r_state, w_next;
    logic [TIME_W-1:0] r_cnt, w_cnt_nxt;
    logic [WU_W-1:0]   r_wcnt, w_wcnt_nxt;
    logic              r_go;
    logic [TIME_W-1:0] r_delay, r_width;
    logic [PWM_W-1:0]  r_duty;
    logic [1:0]        r_ch;
    logic              w_accept, w_go_set, w_strobe, w_pwm;

    // A trig is taken only in ARMED and not while a previous capture is still
    // waiting to launch. Capture happens at the sampling edge; the launch
    // (r_go) is acted on one cycle later, which gives the N+1+delay latency.
    assign w_accept = trig && en && (r_state == ARMED) && !r_go;
    assign w_go_set = w_accept && (cfg_width != '0);

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_wcnt_nxt = r_wcnt;
        case (r_state)
            OFF: begin
                if (en) begin
                    w_next     = WARMUP;
                    w_wcnt_nxt = '0;
                end
            end
            WARMUP: begin
                if (r_wcnt == WU_W'(WARMUP_CYCLES - 1)) w_next = ARMED;
                else                                     w_wcnt_nxt = r_wcnt + WU_W'(1);
            end
            ARMED: begin
                if (r_go) begin
                    w_cnt_nxt = '0;
                    w_next    = (r_delay == '0) ? STROBE : DELAY;
                end
            end
            DELAY: begin
                if (r_cnt == r_delay - TIME_W'(1)) begin
                    w_next    = STROBE;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + TIME_W'(1);
                end
            end
            STROBE: begin
                if (r_cnt == r_width - TIME_W'(1)) w_next    = ARMED;
                else                               w_cnt_nxt = r_cnt + TIME_W'(1);
            end
            default: w_next = OFF;
        endcase
        if (!en) w_next = OFF;
    end

    assign w_strobe = (w_next == STROBE);

    ir_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .run  (w_strobe),
        .duty (r_duty),
        .pwm  (w_pwm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_go    <= 1'b0;
            r_delay <= '0;
            r_width <= '0;
            r_duty  <= '0;
            r_ch    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_go    <= en && w_go_set;
            if (w_accept) begin
                r_delay <= cfg_delay;
                r_width <= cfg_width;
                r_duty  <= cfg_duty;
                r_ch    <= cfg_ch;
            end
        end
    end

    // Outputs are registered from the next state so en=0 clears them on the
    // very next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curren   <= 1'b0;
            ready    <= 1'b0;
            overrun  <= 1'b0;
            irleden  <= 1'b0;
            irpwm    <= 1'b0;
            irleden2 <= 1'b0;
            irpwm2   <= 1'b0;
        end else begin
            curren   <= (w_next != OFF);
            ready    <= (w_next == ARMED) && !w_go_set;
            overrun  <= trig && !w_accept && (w_next != OFF);
            irleden  <= w_strobe && r_ch[0];
            irpwm    <= w_pwm    && r_ch[0];
            irleden2 <= w_strobe && r_ch[1];
            irpwm2   <= w_pwm    && r_ch[1];
        end
    end

endmodule

// File: tb/tb_ir_strobe_ctrl.sv
module tb_ir_strobe_ctrl;

    localparam int PW = 4;
    localparam int TW = 16;

    localparam logic [6:0] C  = 7'h40;
    localparam logic [6:0] R  = 7'h20;
    localparam logic [6:0] O  = 7'h10;
    localparam logic [6:0] L1 = 7'h08;
    localparam logic [6:0] P1 = 7'h04;
    localparam logic [6:0] L2 = 7'h02;
    localparam logic [6:0] P2 = 7'h01;

    logic          clk = 1'b0;
    logic          rst, en, trig;
    logic [TW-1:0] cfg_delay, cfg_width;
    logic [PW-1:0] cfg_duty;
    logic [1:0]    cfg_ch;
    logic          curren, irleden, irpwm, irleden2, irpwm2, ready, overrun;
    logic [6:0]    vec;

    ir_strobe_ctrl #(.PWM_W(PW), .TIME_W(TW), .WARMUP_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .en(en), .trig(trig),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_duty(cfg_duty), .cfg_ch(cfg_ch),
        .curren(curren), .irleden(irleden), .irpwm(irpwm),
        .irleden2(irleden2), .irpwm2(irpwm2), .ready(ready), .overrun(overrun)
    );

    assign vec = {curren, ready, overrun, irleden, irpwm, irleden2, irpwm2};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] v;
    } ev_t;
    ev_t q[$];

    int tests = 0;
    int fails = 0;

    task automatic exp_ev(input int c, input logic [6:0] v);
        ev_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        tests++;
        if (act !== ex) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, ex, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_cfg(input int d, input int w, input int du, input logic [1:0] ch);
        cfg_delay = TW'(d);
        cfg_width = TW'(w);
        cfg_duty  = PW'(du);
        cfg_ch    = ch;
    endtask

    task automatic pulse();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic trig_seq(input logic [31:0] mask);
        trig = mask[0];
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            trig = mask[k];
        end
        @(negedge clk);
        trig = 1'b0;
    endtask

    // Monitor: every change of the output vector is one presented event,
    // compared against the next expected event (cycle and value).
    initial begin
        logic [6:0] prev;
        ev_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (vec !== prev) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %0h at cycle %0d, none expected", vec, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.v !== vec) begin
                        fails++;
                        $display("FAIL event: got %0h at cycle %0d expected %0h at cycle %0d",
                                 vec, cyc, e.v, e.c);
                    end
                end
                prev = vec;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, e;
        rst = 1'b0; en = 1'b0; trig = 1'b0;
        set_cfg(0, 0, 0, 2'b00);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(vec), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Power-up: curren next edge, ready 16 cycles later
        en = 1'b1;
        n = cyc + 1;
        exp_ev(n, C);
        exp_ev(n + 16, C | R);
        wait_cyc(n + 20);

        // Basic strobe; cfg changed after capture must not matter
        set_cfg(3, 20, 4, 2'b01);
        n = cyc + 1;
        exp_ev(n, C);
        exp_ev(n + 4, C | L1 | P1);
        exp_ev(n + 8, C | L1);
        exp_ev(n + 20, C | L1 | P1);
        exp_ev(n + 24, C | R);
        pulse();
        set_cfg(7, 3, 15, 2'b10);
        wait_cyc(n + 30);

        // Overruns in DELAY, in STROBE and on the final STROBE cycle
        set_cfg(3, 20, 4, 2'b01);
        n = cyc + 1;
        exp_ev(n, C);
        exp_ev(n + 2, C | O);
        exp_ev(n + 3, C);
        exp_ev(n + 4, C | L1 | P1);
        exp_ev(n + 8, C | L1);
        exp_ev(n + 10, C | L1 | O);
        exp_ev(n + 11, C | L1);
        exp_ev(n + 20, C | L1 | P1);
        exp_ev(n + 24, C | R | O);
        exp_ev(n + 25, C | R);
        trig_seq(32'h0100_0405);
        wait_cyc(n + 36);

        // Zero width: captured, no strobe, ready stays
        set_cfg(0, 0, 4, 2'b01);
        pulse();
        repeat (6) @(negedge clk);
        chk("width0_ready_leds", 32'({ready, irleden, irleden2}), 32'b100);

        // Zero delay, zero duty, both channels
        set_cfg(0, 5, 0, 2'b11);
        n = cyc + 1;
        exp_ev(n, C);
        exp_ev(n + 1, C | L1 | L2);
        exp_ev(n + 6, C | R);
        pulse();
        wait_cyc(n + 10);

        // Max duty on channel 2: 15 of 16 high
        set_cfg(1, 18, 15, 2'b10);
        n = cyc + 1;
        exp_ev(n, C);
        exp_ev(n + 2, C | L2 | P2);
        exp_ev(n + 17, C | L2);
        exp_ev(n + 18, C | L2 | P2);
        exp_ev(n + 20, C | R);
        pulse();
        wait_cyc(n + 24);

        // en=0 mid-strobe, re-enable, trig during warmup
        set_cfg(2, 10, 15, 2'b10);
        n = cyc + 1;
        e = n + 7;
        exp_ev(n, C);
        exp_ev(n + 3, C | L2 | P2);
        exp_ev(n + 5, 7'h00);
        exp_ev(e, C);
        exp_ev(e + 3, C | O);
        exp_ev(e + 4, C);
        exp_ev(e + 16, C | R);
        pulse();
        wait_cyc(n + 4);
        en = 1'b0;
        wait_cyc(n + 6);
        en = 1'b1;
        wait_cyc(e + 2);
        pulse();
        wait_cyc(e + 20);

        // Asynchronous reset mid-strobe
        set_cfg(0, 10, 4, 2'b01);
        n = cyc + 1;
        exp_ev(n, C);
        exp_ev(n + 1, C | L1 | P1);
        exp_ev(n + 4, 7'h00);
        pulse();
        wait_cyc(n + 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(vec), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        chk("events_left", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
